// File: rtl/conv_axil_pkg.sv
// Shared encodings and register map for the AXI4-Lite launch/poll sequencer.
package conv_axil_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_REQ,
    S_WR_RESP,
    S_GAP,
    S_RD_REQ,
    S_RD_RESP,
    S_FIN
  } state_t;

  localparam logic [3:0]  CTRL_ADDR   = 4'h0;
  localparam logic [3:0]  STATUS_ADDR = 4'h4;
  localparam logic [31:0] CTRL_GO     = 32'h0000_0001;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_WR      = 2'b01;
  localparam logic [1:0] ERR_RD      = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

endpackage

// File: rtl/conv_axil_sequencer.sv
// Writes GO to CTRL, then polls STATUS bit 0 with a fixed idle gap until set,
// a bus error, or the poll budget runs out.
module conv_axil_sequencer
  import conv_axil_pkg::*;
#(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 4,
  parameter int unsigned POLL_GAP           = 16,
  parameter int unsigned MAX_POLLS          = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic [1:0]                    err_code,
  output logic [31:0]                   status_q,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic                          m_axi_awvalid,
  input  logic                          m_axi_awready,
  output logic [31:0]                   m_axi_wdata,
  output logic [3:0]                    m_axi_wstrb,
  output logic                          m_axi_wvalid,
  input  logic                          m_axi_wready,
  input  logic [1:0]                    m_axi_bresp,
  input  logic                          m_axi_bvalid,
  output logic                          m_axi_bready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  input  logic [31:0]                   m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready
);

  localparam int unsigned GAP_W  = (POLL_GAP > 1)  ? $clog2(POLL_GAP)  : 1;
  localparam int unsigned POLL_W = (MAX_POLLS > 1) ? $clog2(MAX_POLLS) : 1;
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(POLL_GAP - 1);
  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(MAX_POLLS - 1);

  state_t              state_q, state_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                arvalid_q, arvalid_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [POLL_W-1:0]   poll_q, poll_d;
  logic [1:0]          err_q, err_d;
  logic [31:0]         status_r, status_d;
  logic                aw_ok, w_ok;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      gap_q     <= '0;
      poll_q    <= '0;
      err_q     <= ERR_OK;
      status_r  <= '0;
    end else begin
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      gap_q     <= gap_d;
      poll_q    <= poll_d;
      err_q     <= err_d;
      status_r  <= status_d;
    end
  end

  // Valids are registered; ready only steers the next-state, never an output.
  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    gap_d     = gap_q;
    poll_d    = poll_q;
    err_d     = err_q;
    status_d  = status_r;
    aw_ok     = !awvalid_q || m_axi_awready;
    w_ok      = !wvalid_q || m_axi_wready;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_WR_REQ;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          err_d     = ERR_OK;
          poll_d    = '0;
        end
      end
      S_WR_REQ: begin
        if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axi_wready)   wvalid_d  = 1'b0;
        if (aw_ok && w_ok)              state_d   = S_WR_RESP;
      end
      S_WR_RESP: begin
        if (m_axi_bvalid) begin
          if (m_axi_bresp != RESP_OKAY) begin
            err_d   = ERR_WR;
            state_d = S_FIN;
          end else begin
            gap_d   = '0;
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          arvalid_d = 1'b1;
          state_d   = S_RD_REQ;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      S_RD_REQ: begin
        if (m_axi_arready) begin
          arvalid_d = 1'b0;
          state_d   = S_RD_RESP;
        end
      end
      S_RD_RESP: begin
        if (m_axi_rvalid) begin
          status_d = m_axi_rdata;
          if (m_axi_rresp != RESP_OKAY) begin
            err_d   = ERR_RD;
            state_d = S_FIN;
          end else if (m_axi_rdata[0]) begin
            err_d   = ERR_OK;
            state_d = S_FIN;
          end else if (poll_q == POLL_LAST) begin
            err_d   = ERR_TIMEOUT;
            state_d = S_FIN;
          end else begin
            poll_d  = poll_q + 1'b1;
            gap_d   = '0;
            state_d = S_GAP;
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy          = (state_q != S_IDLE) && (state_q != S_FIN);
  assign done          = (state_q == S_FIN);
  assign err_code      = err_q;
  assign status_q      = status_r;
  assign m_axi_awaddr  = C_M_AXI_ADDR_WIDTH'(CTRL_ADDR);
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = CTRL_GO;
  assign m_axi_wstrb   = '1;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = (state_q == S_WR_RESP);
  assign m_axi_araddr  = C_M_AXI_ADDR_WIDTH'(STATUS_ADDR);
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = (state_q == S_RD_RESP);

endmodule

// File: tb/tb_conv_axil_sequencer.sv
// Scoreboarded bench: a reactive AXI4-Lite slave checks each transaction and
// completion against expectations queued when a sequence is launched.
module tb_conv_axil_sequencer;
  import conv_axil_pkg::*;

  localparam int unsigned TB_GAP = 3;
  localparam int unsigned TB_MAX = 4;

  logic        clk = 1'b0;
  logic        rst, start, busy, done;
  logic [1:0]  err_code;
  logic [31:0] status_q;
  logic [3:0]  m_axi_awaddr, m_axi_araddr, m_axi_wstrb;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [31:0] m_axi_wdata, m_axi_rdata;
  logic [1:0]  m_axi_bresp, m_axi_rresp;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic        m_axi_rvalid, m_axi_rready;

  always #5 clk = ~clk;

  conv_axil_sequencer #(
    .C_M_AXI_ADDR_WIDTH(4),
    .POLL_GAP(TB_GAP),
    .MAX_POLLS(TB_MAX)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .err_code(err_code), .status_q(status_q),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  typedef struct { bit is_rd; logic [3:0] addr; logic [31:0] data; } txn_t;
  typedef struct { logic [1:0] err; logic [31:0] status; } res_t;

  txn_t        exp_q[$];
  res_t        res_q[$];
  logic [31:0] rd_script[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Slave configuration, written by the stimulus process.
  int         aw_delay = 0, w_delay = 0, ar_delay = 0, r_delay = 0;
  logic [1:0] cfg_bresp = 2'b00, cfg_rresp = 2'b00;

  // Slave/monitor state.
  int          aw_cnt, w_cnt, ar_cnt, r_cnt, cyc, last_cyc, viol, bviol;
  bit          aw_done, w_done, r_pend, aw_hold, w_hold, ar_hold, b_rdy, r_rdy;
  logic [3:0]  cap_awaddr, cap_wstrb, hold_awaddr, hold_araddr;
  logic [31:0] cap_wdata, hold_wdata;
  txn_t        e;
  res_t        r;

  initial begin
    {m_axi_awready, m_axi_wready, m_axi_arready, m_axi_bvalid, m_axi_rvalid} = '0;
    m_axi_bresp = 2'b00; m_axi_rresp = 2'b00; m_axi_rdata = '0;
    cyc = 0; last_cyc = 0; viol = 0; bviol = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        {m_axi_awready, m_axi_wready, m_axi_arready, m_axi_bvalid, m_axi_rvalid} = '0;
        {aw_done, w_done, r_pend, aw_hold, w_hold, ar_hold, b_rdy, r_rdy} = '0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; r_cnt = 0;
        last_cyc = cyc;
      end else begin
        if (aw_hold && (!m_axi_awvalid || m_axi_awaddr !== hold_awaddr)) viol++;
        if (w_hold && (!m_axi_wvalid || m_axi_wdata !== hold_wdata)) viol++;
        if (ar_hold && (!m_axi_arvalid || m_axi_araddr !== hold_araddr)) viol++;
        // A ready left high from the last negedge means that handshake just completed.
        if (m_axi_awready) begin aw_done = 1; check_eq("aw_drop", 32'(m_axi_awvalid), 0); end
        if (m_axi_wready)  begin w_done = 1;  check_eq("w_drop", 32'(m_axi_wvalid), 0); end
        if (m_axi_bvalid && b_rdy) begin m_axi_bvalid = 0; last_cyc = cyc; end
        if (m_axi_rvalid && r_rdy) begin m_axi_rvalid = 0; last_cyc = cyc; end
        if (m_axi_arready) begin
          check_eq("ar_drop", 32'(m_axi_arvalid), 0);
          r_pend = 1; r_cnt = r_delay;
        end
        if (aw_done && w_done) begin
          aw_done = 0; w_done = 0;
          check_eq("wr_expected", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_eq("wr_kind", 32'(e.is_rd), 0);
            check_eq("wr_addr", 32'(cap_awaddr), 32'(e.addr));
            check_eq("wr_data", cap_wdata, e.data);
            check_eq("wr_strb", 32'(cap_wstrb), 32'hF);
          end
          m_axi_bvalid = 1; m_axi_bresp = cfg_bresp;
        end
        if (r_pend) begin
          if (r_cnt == 0) begin
            m_axi_rvalid = 1; m_axi_rresp = cfg_rresp;
            m_axi_rdata  = (rd_script.size() != 0) ? rd_script.pop_front() : 32'h0;
            r_pend = 0;
          end else r_cnt--;
        end
        m_axi_awready = 0;
        if (m_axi_awvalid) begin
          if (aw_cnt >= aw_delay) begin m_axi_awready = 1; aw_cnt = 0; cap_awaddr = m_axi_awaddr; end
          else aw_cnt++;
        end else aw_cnt = 0;
        aw_hold = m_axi_awvalid && !m_axi_awready; hold_awaddr = m_axi_awaddr;
        m_axi_wready = 0;
        if (m_axi_wvalid) begin
          if (w_cnt >= w_delay) begin
            m_axi_wready = 1; w_cnt = 0; cap_wdata = m_axi_wdata; cap_wstrb = m_axi_wstrb;
          end else w_cnt++;
        end else w_cnt = 0;
        w_hold = m_axi_wvalid && !m_axi_wready; hold_wdata = m_axi_wdata;
        if (m_axi_arvalid && !ar_hold) begin
          check_eq("poll_gap", 32'(cyc - last_cyc), TB_GAP);
          check_eq("rd_expected", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_eq("rd_kind", 32'(e.is_rd), 1);
            check_eq("rd_addr", 32'(m_axi_araddr), 32'(e.addr));
          end
        end
        m_axi_arready = 0;
        if (m_axi_arvalid) begin
          if (ar_cnt >= ar_delay) begin m_axi_arready = 1; ar_cnt = 0; end
          else ar_cnt++;
        end else ar_cnt = 0;
        ar_hold = m_axi_arvalid && !m_axi_arready; hold_araddr = m_axi_araddr;
        b_rdy = m_axi_bready;
        r_rdy = m_axi_rready;
        if (m_axi_bready && !m_axi_bvalid) bviol++;
        if (done) begin
          check_eq("res_expected", 32'(res_q.size() != 0), 1);
          if (res_q.size() != 0) begin
            r = res_q.pop_front();
            check_eq("err_code", 32'(err_code), 32'(r.err));
            check_eq("status_q", status_q, r.status);
            check_eq("done_busy", 32'(busy), 0);
          end
        end
      end
    end
  end

  task automatic exp_write();
    exp_q.push_back('{is_rd: 1'b0, addr: CTRL_ADDR, data: CTRL_GO});
  endtask

  task automatic exp_read(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back('{is_rd: 1'b1, addr: STATUS_ADDR, data: 32'h0});
  endtask

  task automatic exp_done(input logic [1:0] err, input logic [31:0] status);
    res_q.push_back('{err: err, status: status});
  endtask

  task automatic launch();
    start = 1;
    @(posedge clk); #2;
    start = 0;
  endtask

  // Returns in the IDLE cycle following FIN; start is released there.
  task automatic wait_done(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #2;
      if (done) begin seen = 1; break; end
    end
    check_eq("done_seen", 32'(seen), 1);
    @(posedge clk); #2;
    start = 0;
    check_eq("done_pulse", 32'(done), 0);
    check_eq("idle_busy", 32'(busy), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ctrl"}, 32'({busy, done, err_code, m_axi_awvalid, m_axi_wvalid,
                                  m_axi_arvalid, m_axi_bready, m_axi_rready}), 0);
    check_eq({tag, "_status"}, status_q, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen;
    rst = 1; start = 0;
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("por");
    rst = 0;
    @(posedge clk); #2;

    // Nominal: two not-ready polls then ready.
    rd_script = '{32'h0, 32'h0, 32'h1};
    exp_write(); exp_read(3); exp_done(ERR_OK, 32'h1);
    launch(); wait_done(300);

    // Staggered write channels, delayed arready, full-word status capture.
    aw_delay = 0; w_delay = 3; ar_delay = 2;
    rd_script = '{32'hA5A5_0001};
    exp_write(); exp_read(1); exp_done(ERR_OK, 32'hA5A5_0001);
    launch(); wait_done(300);
    w_delay = 0; ar_delay = 0;

    // Write response error: no polling, status untouched.
    cfg_bresp = 2'b10;
    exp_write(); exp_done(ERR_WR, 32'hA5A5_0001);
    launch(); wait_done(300);
    cfg_bresp = 2'b00;

    // Timeout after exactly MAX_POLLS reads.
    rd_script = '{32'h0, 32'h0, 32'h0, 32'h0};
    exp_write(); exp_read(TB_MAX); exp_done(ERR_TIMEOUT, 32'h0);
    launch(); wait_done(300);

    // Read error outranks a set ready bit.
    cfg_rresp = 2'b10;
    rd_script = '{32'h3};
    exp_write(); exp_read(1); exp_done(ERR_RD, 32'h3);
    launch(); wait_done(300);
    cfg_rresp = 2'b00;

    // Reset while waiting for read data.
    r_delay = 5;
    rd_script = '{32'h0, 32'h0};
    exp_write(); exp_read(1);
    launch();
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      if (m_axi_rready) begin seen = 1; break; end
      @(posedge clk); #2;
    end
    check_eq("reach_rd_resp", 32'(seen), 1);
    rst = 1;
    @(posedge clk); #2;
    check_reset_outputs("mid_rst");
    @(posedge clk); #2;
    rst = 0;
    exp_q.delete(); res_q.delete(); rd_script.delete();
    r_delay = 0;
    rd_script = '{32'h1};
    exp_write(); exp_read(1); exp_done(ERR_OK, 32'h1);
    launch(); wait_done(300);

    // start held through busy and FIN: one sequence only.
    rd_script = '{32'h1};
    exp_write(); exp_read(1); exp_done(ERR_OK, 32'h1);
    start = 1;
    wait_done(300);
    repeat (10) begin @(posedge clk); #2; end
    check_eq("no_relaunch", 32'(busy), 0);

    check_eq("valid_hold_viol", 32'(viol), 0);
    check_eq("bready_early", 32'(bviol), 0);
    check_eq("txn_left", 32'(exp_q.size()), 0);
    check_eq("res_left", 32'(res_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_axil_sequencer.md
CONV_AXIL_SEQUENCER -- requirements
Module: conv_axil_sequencer

Interface
REQ-001 SHALL have parameter C_M_AXI_ADDR_WIDTH, default 4, AXI4-Lite address width; data width fixed at 32.
REQ-002 SHALL have parameter POLL_GAP, default 16, idle cycles between consecutive STATUS reads (>=1).
REQ-003 SHALL have parameter MAX_POLLS, default 1024, STATUS reads before timeout (>=1).
REQ-004 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  in  1  synchronous active-high reset.
REQ-006 SHALL have port start  in  1  one-cycle launch request.
REQ-007 SHALL have port busy  out  1  high from launch accepted until done.
REQ-008 SHALL have port done  out  1  one-cycle completion pulse.
REQ-009 SHALL have port err_code  out  2  00 ok, 01 write resp error, 10 read resp error, 11 timeout; valid with done, held until next launch.
REQ-010 SHALL have port status_q  out  32  last STATUS rdata captured.
REQ-011 SHALL have port m_axi_awaddr  out  C_M_AXI_ADDR_WIDTH  write address.
REQ-012 SHALL have port m_axi_awvalid  out  1  write address valid.
REQ-013 SHALL have port m_axi_awready  in  1  write address ready.
REQ-014 SHALL have port m_axi_wdata  out  32  write data.
REQ-015 SHALL have port m_axi_wstrb  out  4  write strobes, constant 4'b1111.
REQ-016 SHALL have port m_axi_wvalid  out  1  write data valid.
REQ-017 SHALL have port m_axi_wready  in  1  write data ready.
REQ-018 SHALL have port m_axi_bresp  in  2  write response.
REQ-019 SHALL have port m_axi_bvalid  in  1  write response valid.
REQ-020 SHALL have port m_axi_bready  out  1  write response ready.
REQ-021 SHALL have port m_axi_araddr  out  C_M_AXI_ADDR_WIDTH  read address.
REQ-022 SHALL have port m_axi_arvalid  out  1  read address valid.
REQ-023 SHALL have port m_axi_arready  in  1  read address ready.
REQ-024 SHALL have port m_axi_rdata  in  32  read data.
REQ-025 SHALL have port m_axi_rresp  in  2  read response.
REQ-026 SHALL have port m_axi_rvalid  in  1  read data valid.
REQ-027 SHALL have port m_axi_rready  out  1  read data ready.

Function
REQ-028 SHALL implement FSM IDLE, WR_REQ, WR_RESP, GAP, RD_REQ, RD_RESP, FIN; start sampled only in IDLE, ignored otherwise (incl. the FIN cycle).
REQ-029 IDLE+start SHALL enter WR_REQ next cycle: busy=1, err_code=00, poll counter=0, awaddr=0x0, wdata=32'h1, awvalid=wvalid=1 asserted in the same cycle.
REQ-030 In WR_REQ each valid SHALL drop the cycle after its own ready handshake; other valid held; both handshakes complete -> WR_RESP.
REQ-031 WR_RESP SHALL drive bready=1; on bvalid: bresp!=00 -> FIN err 01, else -> GAP.
REQ-032 GAP SHALL count exactly POLL_GAP cycles, then enter RD_REQ with araddr=0x4, arvalid=1 held until arready, then RD_RESP.
REQ-033 RD_RESP SHALL drive rready=1; on rvalid: status_q<=rdata; rresp!=00 -> FIN err 10; rdata[0]=1 -> FIN err 00; counter==MAX_POLLS-1 -> FIN err 11; else counter+1 -> GAP.
REQ-034 FIN SHALL pulse done=1 for one cycle, busy=0 same cycle, then IDLE.
REQ-035 Address/data outputs SHALL remain stable while corresponding valid is high; no valid SHALL depend combinationally on any ready.
REQ-036 At most one AXI transaction SHALL be outstanding.

Reset
REQ-037 rst=1 at any clock edge, including mid-transaction, SHALL force IDLE, all valids/readies 0, busy=0, done=0, err_code=00, status_q=0, counters 0 at that edge.

Structure
REQ-038 Package conv_axil_pkg SHALL hold state encoding, CTRL_ADDR=4'h0, STATUS_ADDR=4'h4, RESP_OKAY=2'b00, err code constants; single module, no sub-module.

Verification
REQ-039 start, slave OKAY, STATUS reads 0,0,1 -> 1 write (addr 0, data 1), 3 reads at addr 4 spaced >=POLL_GAP, done with err 00, status_q=1.
REQ-040 awready 3 cycles before wready -> awvalid drops after its handshake, wvalid held, exactly one write, bready only after both.
REQ-041 bresp=2'b10 -> no read issued, done with err 01.
REQ-042 MAX_POLLS=4, STATUS always 0 -> exactly 4 reads, done with err 11.
REQ-043 rst pulsed during RD_RESP, then start -> all outputs zero after reset edge; fresh write sequence follows.
REQ-044 start held high during busy and on FIN cycle -> exactly one sequence until the IDLE cycle.
